// File: rtl/accum_result_serializer_if.sv
// Result stream from the accumulator serializer toward the activation/writeback stage.
// The serializer drives the master side; the consumer sits on the slave side.
interface accum_result_serializer_if #(
    parameter int unsigned CFG_W = 4
);
    logic [31:0]      res_o;
    logic [CFG_W-1:0] res_idx_o;
    logic             res_valid_o;
    logic             res_last_o;
    logic             res_ready_i;

    modport master (
        output res_o,
        output res_idx_o,
        output res_valid_o,
        output res_last_o,
        input  res_ready_i
    );

    modport slave (
        input  res_o,
        input  res_idx_o,
        input  res_valid_o,
        input  res_last_o,
        output res_ready_i
    );
endinterface

// File: rtl/accum_result_serializer.sv
// Captures one accumulator frame and emits the finished neuron sums one per beat.
// Define ACC_SERIALIZER_RELU_EN to clamp negative emitted results to zero.
module accum_result_serializer #(
    parameter int unsigned IN_SIZE = 16,
    parameter int unsigned CFG_W   = $clog2(IN_SIZE)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [31:0]               data_i [0:IN_SIZE-1],
    input  logic                      frame_valid_i,
    output logic                      frame_ready_o,
    input  logic [CFG_W-1:0]          group_cfg_i,
    accum_result_serializer_if.master res_if
);

    localparam int unsigned GW = CFG_W + 1;

    typedef logic [31:0] data_t;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_e;

    state_e           state_q, state_d;
    logic [CFG_W-1:0] ptr_q, ptr_d;
    logic [GW-1:0]    g_q, g_d;
    logic [GW-1:0]    k_q, k_d;
    data_t            res_q, res_d;
    logic             last_q, last_d;
    data_t            buf_q [0:IN_SIZE-1];

    logic [GW-1:0]    g_new;
    logic [GW-1:0]    k_new;
    logic             last_beat;
    logic             hs;
    logic             last_hs;
    logic             adv_hs;
    logic             capture;
    int unsigned      lane;
    data_t            sel_val;
    data_t            out_val;

    // Group size from config, clamped so at least one lane is selected.
    always_comb begin
        g_new = GW'(group_cfg_i) + GW'(1);
        if (g_new > GW'(IN_SIZE)) begin
            g_new = GW'(IN_SIZE);
        end
        k_new = GW'(IN_SIZE / 32'(g_new));
    end

    always_comb begin
        last_beat     = ({1'b0, ptr_q} == (k_q - GW'(1)));
        hs            = (state_q == S_SEND) && res_if.res_ready_i;
        last_hs       = hs && last_beat;
        adv_hs        = hs && !last_beat;
        frame_ready_o = (state_q == S_IDLE) || last_hs;
        capture       = frame_valid_i && frame_ready_o;
    end

    // The next beat's lane comes straight from data_i on capture, otherwise from the buffer.
    always_comb begin
        if (capture) begin
            lane = 32'(g_new) - 32'd1;
        end else begin
            lane = (32'(ptr_q) + 32'd2) * 32'(g_q) - 32'd1;
        end
        sel_val = '0;
        for (int unsigned i = 0; i < IN_SIZE; i++) begin
            if (lane == i) begin
                sel_val = capture ? data_i[i] : buf_q[i];
            end
        end
`ifdef ACC_SERIALIZER_RELU_EN
        out_val = sel_val[31] ? '0 : sel_val;
`else
        out_val = sel_val;
`endif
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        k_d     = k_q;
        res_d   = res_q;
        last_d  = last_q;
        if (capture) begin
            state_d = S_SEND;
            ptr_d   = '0;
            g_d     = g_new;
            k_d     = k_new;
            res_d   = out_val;
            last_d  = (k_new == GW'(1));
        end else if (adv_hs) begin
            ptr_d   = ptr_q + CFG_W'(1);
            res_d   = out_val;
            last_d  = (({1'b0, ptr_q} + GW'(2)) == k_q);
        end else if (last_hs) begin
            state_d = S_IDLE;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            k_q     <= '0;
            res_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            k_q     <= k_d;
            res_q   <= res_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < IN_SIZE; i++) begin
                buf_q[i] <= '0;
            end
        end else if (capture) begin
            for (int unsigned i = 0; i < IN_SIZE; i++) begin
                buf_q[i] <= data_i[i];
            end
        end
    end

    assign res_if.res_o       = res_q;
    assign res_if.res_idx_o   = ptr_q;
    assign res_if.res_valid_o = (state_q == S_SEND);
    assign res_if.res_last_o  = last_q;

    stall_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (res_if.res_valid_o && !res_if.res_ready_i) |=>
            (res_if.res_valid_o && $stable(res_if.res_o) &&
             $stable(res_if.res_idx_o) && $stable(res_if.res_last_o)));

endmodule

// File: tb/tb_accum_result_serializer.sv
// Directed bench for accum_result_serializer with hand-computed expected beats.
module tb_accum_result_serializer;

    localparam int unsigned IN_SIZE = 16;
    localparam int unsigned CFG_W   = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [31:0]      data_i [0:IN_SIZE-1];
    logic             frame_valid_i;
    logic             frame_ready_o;
    logic [CFG_W-1:0] group_cfg_i;

    accum_result_serializer_if #(.CFG_W(CFG_W)) rif ();

    accum_result_serializer #(
        .IN_SIZE(IN_SIZE),
        .CFG_W  (CFG_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .data_i       (data_i),
        .frame_valid_i(frame_valid_i),
        .frame_ready_o(frame_ready_o),
        .group_cfg_i  (group_cfg_i),
        .res_if       (rif)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] exp_v [0:IN_SIZE-1];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [31:0] val, input int unsigned idx,
                              input logic last);
        check_val($sformatf("%s[%0d]_valid", tag, idx), 32'(rif.res_valid_o), 32'd1);
        check_val($sformatf("%s[%0d]_res", tag, idx), rif.res_o, val);
        check_val($sformatf("%s[%0d]_idx", tag, idx), 32'(rif.res_idx_o), idx);
        check_val($sformatf("%s[%0d]_last", tag, idx), 32'(rif.res_last_o), 32'(last));
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_idle_valid"}, 32'(rif.res_valid_o), 32'd0);
        check_val({tag, "_idle_frdy"}, 32'(frame_ready_o), 32'd1);
    endtask

    // Caller loads data_i and exp_v; consumer always ready.
    task automatic stream_frame(input string tag, input logic [CFG_W-1:0] cfg, input int unsigned n);
        @(negedge clk_i);
        group_cfg_i     = cfg;
        frame_valid_i   = 1'b1;
        rif.res_ready_i = 1'b1;
        #1 check_val({tag, "_cap_frdy"}, 32'(frame_ready_o), 32'd1);
        @(negedge clk_i);
        frame_valid_i = 1'b0;
        group_cfg_i   = ~cfg;
        for (int unsigned i = 0; i < IN_SIZE; i++) data_i[i] = 32'hDEAD_0000 | 32'(i);
        for (int unsigned b = 0; b < n; b++) begin
            #1;
            check_beat(tag, exp_v[b], b, b == n - 1);
            check_val($sformatf("%s[%0d]_frdy", tag, b), 32'(frame_ready_o), 32'(b == n - 1));
            @(negedge clk_i);
        end
        #1 check_idle(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int unsigned b;
        int unsigned c;

        rst_ni          = 1'b0;
        frame_valid_i   = 1'b0;
        group_cfg_i     = '0;
        rif.res_ready_i = 1'b0;
        for (int unsigned i = 0; i < IN_SIZE; i++) data_i[i] = 32'h5555_0000 | 32'(i);

        repeat (2) @(negedge clk_i);
        #1;
        check_val("rst_valid", 32'(rif.res_valid_o), 32'd0);
        check_val("rst_frdy", 32'(frame_ready_o), 32'd1);
        check_val("rst_res", rif.res_o, 32'd0);
        check_val("rst_idx", 32'(rif.res_idx_o), 32'd0);
        check_val("rst_last", 32'(rif.res_last_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1 check_idle("post_rst");

        // Every lane is a result.
        for (int unsigned i = 0; i < IN_SIZE; i++) begin
            data_i[i] = 32'd100 + 32'(i);
            exp_v[i]  = 32'd100 + 32'(i);
        end
        stream_frame("cfg0", 4'd0, 16);

        // Groups of three: lanes 2,5,8,11,14.
        for (int unsigned i = 0; i < IN_SIZE; i++) data_i[i] = 32'(i);
        exp_v[0] = 32'd2; exp_v[1] = 32'd5; exp_v[2] = 32'd8; exp_v[3] = 32'd11; exp_v[4] = 32'd14;
        stream_frame("cfg2", 4'd2, 5);

        // One group spanning the whole frame.
        for (int unsigned i = 0; i < IN_SIZE; i++) data_i[i] = 32'(i);
        exp_v[0] = 32'd15;
        stream_frame("cfg15", 4'd15, 1);

        // Backpressure with ready pattern 1,0,0 repeating.
        for (int unsigned i = 0; i < IN_SIZE; i++) data_i[i] = 32'(i) * 32'd10;
        exp_v[0] = 32'd30; exp_v[1] = 32'd70; exp_v[2] = 32'd110; exp_v[3] = 32'd150;
        @(negedge clk_i);
        group_cfg_i     = 4'd3;
        frame_valid_i   = 1'b1;
        rif.res_ready_i = 1'b0;
        @(negedge clk_i);
        frame_valid_i = 1'b0;
        for (int unsigned i = 0; i < IN_SIZE; i++) data_i[i] = 32'hBEEF_0000;
        b = 0;
        c = 0;
        while (b < 4 && c < 40) begin
            rif.res_ready_i = (c % 3 == 0);
            #1;
            check_beat("bp", exp_v[b], b, b == 3);
            check_val($sformatf("bp[%0d]_c%0d_frdy", b, c), 32'(frame_ready_o),
                      32'(rif.res_ready_i && b == 3));
            if (rif.res_ready_i) b++;
            c++;
            @(negedge clk_i);
        end
        check_val("bp_beats", b, 32'd4);
        rif.res_ready_i = 1'b1;
        #1 check_idle("bp");

        // Back-to-back: B is captured on A's last handshake.
        @(negedge clk_i);
        for (int unsigned i = 0; i < IN_SIZE; i++) data_i[i] = 32'd200 + 32'(i);
        group_cfg_i     = 4'd1;
        frame_valid_i   = 1'b1;
        rif.res_ready_i = 1'b1;
        #1 check_val("b2b_cap_frdy", 32'(frame_ready_o), 32'd1);
        @(negedge clk_i);
        for (int unsigned i = 0; i < IN_SIZE; i++) data_i[i] = 32'd300 + 32'(i);
        group_cfg_i = 4'd7;
        for (int unsigned k = 0; k < 8; k++) begin
            #1;
            check_beat("b2b_a", 32'd201 + 32'd2 * 32'(k), k, k == 7);
            check_val($sformatf("b2b_a[%0d]_frdy", k), 32'(frame_ready_o), 32'(k == 7));
            @(negedge clk_i);
        end
        frame_valid_i = 1'b0;
        for (int unsigned i = 0; i < IN_SIZE; i++) data_i[i] = 32'hDEAD_0000;
        #1;
        check_beat("b2b_b", 32'd307, 0, 1'b0);
        check_val("b2b_b[0]_frdy", 32'(frame_ready_o), 32'd0);
        @(negedge clk_i);
        #1;
        check_beat("b2b_b", 32'd315, 1, 1'b1);
        check_val("b2b_b[1]_frdy", 32'(frame_ready_o), 32'd1);
        @(negedge clk_i);
        #1 check_idle("b2b");

        // Negative lane: clamped only when the ReLU build is selected.
        for (int unsigned i = 0; i < IN_SIZE; i++) begin
            data_i[i] = 32'(i);
            exp_v[i]  = 32'(i);
        end
        data_i[3] = 32'hFFFF_FFFB;
        data_i[4] = 32'd7;
`ifdef ACC_SERIALIZER_RELU_EN
        exp_v[3] = 32'd0;
`else
        exp_v[3] = 32'hFFFF_FFFB;
`endif
        exp_v[4] = 32'd7;
        stream_frame("relu", 4'd0, 16);

        // Reset asserted mid-frame discards the rest without a last beat.
        @(negedge clk_i);
        for (int unsigned i = 0; i < IN_SIZE; i++) data_i[i] = 32'd500 + 32'(i);
        group_cfg_i     = 4'd0;
        frame_valid_i   = 1'b1;
        rif.res_ready_i = 1'b1;
        @(negedge clk_i);
        frame_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1 check_beat("mid", 32'd502, 2, 1'b0);
        rst_ni = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(rif.res_valid_o), 32'd0);
        check_val("mid_rst_frdy", 32'(frame_ready_o), 32'd1);
        check_val("mid_rst_idx", 32'(rif.res_idx_o), 32'd0);
        check_val("mid_rst_last", 32'(rif.res_last_o), 32'd0);
        check_val("mid_rst_res", rif.res_o, 32'd0);
        @(posedge clk_i);
        #1;
        check_val("mid_rst_edge_valid", 32'(rif.res_valid_o), 32'd0);
        check_val("mid_rst_edge_last", 32'(rif.res_last_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1 check_idle("mid_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
